// File: rtl/alu_shift_pkg.sv
// Shared types and sizing helpers for the multi-cycle left shifter.
package alu_shift_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} shift_state_t;

  // Stage counter width: one more bit than the log2 of the stage count.
  function automatic int stage_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/shift_left_seq_stage.sv
// One log-shifter stage: shifts acc by 2**stage when en, filling the LSBs.
module shift_left_stage
  import alu_shift_pkg::*;
#(
  parameter int Nbits = 4,
  parameter int IW    = stage_idx_w(Nbits)
) (
  input  logic [Nbits-1:0] acc,
  input  logic             fill,
  input  logic [IW-1:0]    stage,
  input  logic             en,
  output logic [Nbits-1:0] acc_next,
  output logic             lost
);

  localparam int               LOG  = $clog2(Nbits);
  localparam logic [Nbits-1:0] ONES = '1;

  int sh;

  always_comb begin
    acc_next = acc;
    lost     = 1'b0;
    sh       = 0;
    if (en) begin
      // Stages whose shift distance reaches the full width flush the operand.
      if (stage >= IW'(LOG)) begin
        acc_next = {Nbits{fill}};
        lost     = |acc;
      end else begin
        sh       = 1 << stage;
        acc_next = (acc << sh) | (fill ? ~(ONES << sh) : '0);
        lost     = |(acc & ~(ONES >> sh));
      end
    end
  end

endmodule

// File: rtl/shift_left_seq.sv
// Multi-cycle logical left shifter, one stage per clock, with overflow
// detection and valid/ready handshakes on both sides.
module shift_left_seq
  import alu_shift_pkg::*;
#(
  parameter int Nbits = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ADD_LSB,
  input  logic [Nbits-1:0] A,
  input  logic [Nbits-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Nbits-1:0] OUT,
  output logic             OVERFLOW
);

  localparam int IW = stage_idx_w(Nbits);

  shift_state_t     state_q;
  logic [Nbits-1:0] acc_q;
  logic [Nbits-1:0] b_q;
  logic             fill_q;
  logic             ovf_q;
  logic [IW-1:0]    idx_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [Nbits-1:0] out_q;
  logic             overflow_q;

  logic [Nbits-1:0] acc_d;
  logic             ovf_d;
  logic             lost;
  logic [Nbits-1:0] b_sh;
  logic             last_stage;

  assign b_sh       = b_q >> idx_q;
  assign last_stage = (idx_q == IW'(Nbits - 1));
  assign ovf_d      = ovf_q | lost;

  shift_left_stage #(.Nbits(Nbits), .IW(IW)) u_stage (
    .acc      (acc_q),
    .fill     (fill_q),
    .stage    (idx_q),
    .en       (b_sh[0]),
    .acc_next (acc_d),
    .lost     (lost)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      b_q         <= '0;
      fill_q      <= 1'b0;
      ovf_q       <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            acc_q      <= A;
            b_q        <= B;
            fill_q     <= ADD_LSB;
            ovf_q      <= 1'b0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc_q <= acc_d;
          ovf_q <= ovf_d;
          idx_q <= idx_q + IW'(1);
          if (last_stage) begin
            out_q       <= acc_d;
            overflow_q  <= ovf_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // in_ready returns only after the handoff edge, never on it.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign OUT       = out_q;
  assign OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_shift_left_seq.sv
// Self-checking bench for shift_left_seq: directed cases plus a random
// back-to-back stream checked against a full-width arithmetic model.
module tb_shift_left_seq;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         add_lsb;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_w;
  logic         ovf_w;

  int total = 0;
  int bad   = 0;

  shift_left_seq #(.Nbits(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ADD_LSB   (add_lsb),
    .A         (a),
    .B         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .OUT       (out_w),
    .OVERFLOW  (ovf_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift into a wide word so every bit pushed past the MSB is still visible.
  function automatic logic [N:0] model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                       input logic f);
    logic [63:0] full;
    full = (64'(av) << bv) | (f ? ((64'd1 << bv) - 64'd1) : 64'd0);
    return {|full[63:N], full[N-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with the unit idle; returns at a negedge after handoff.
  task automatic run_op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic f, input int hold);
    logic [N:0] exp;
    int lat;
    exp = model(av, bv, f);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = av; b = bv; add_lsb = f; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = N'($urandom); b = N'($urandom); add_lsb = 1'($urandom);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        in_valid = 1'b1;
        a = ~av;
      end
      if (k == 2) in_valid = 1'b0;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(N));
    chk({tag, "_out"}, 32'(out_w), 32'(exp[N-1:0]));
    chk({tag, "_ovf"}, 32'(ovf_w), 32'(exp[N]));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_out"}, 32'({ovf_w, out_w}), 32'(exp));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_handoff_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_handoff_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [N:0] q[$];
    logic [N:0] e;
    int sent;
    int got;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    add_lsb = 1'b0; a = '0; b = '0;
    #12;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out", 32'(out_w), 32'd0);
    chk("reset_ovf", 32'(ovf_w), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("t1", 4'b0011, 4'd1, 1'b0, 0);
    chk("t1_exact", 32'(out_w), 32'b0110);
    run_op("t2", 4'b1001, 4'd2, 1'b1, 0);
    chk("t2_exact", 32'({ovf_w, out_w}), 32'b10111);
    run_op("t3a", 4'b0001, 4'd5, 1'b0, 0);
    chk("t3a_exact", 32'({ovf_w, out_w}), 32'b10000);
    run_op("t3b", 4'b0000, 4'd5, 1'b0, 0);
    run_op("t4_hold", 4'b1011, 4'd3, 1'b1, 3);
    run_op("bmax", 4'b0110, 4'd15, 1'b1, 0);

    // Reset in the middle of SHIFT while idx=2.
    a = 4'b1111; b = 4'd3; add_lsb = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_ready", 32'(in_ready), 32'd1);
    chk("t5_rst_out", 32'(out_w), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("t5_after", 4'b0101, 4'd0, 1'b0, 0);
    chk("t5_after_exact", 32'({ovf_w, out_w}), 32'b00101);

    // Back-to-back random stream.
    sent = 0;
    got  = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 * (N + 2) + 100 && got < 200; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("b2b_unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("b2b_result", 32'({ovf_w, out_w}), 32'(e));
          got++;
        end
      end
      a = N'($urandom); b = N'($urandom); add_lsb = 1'($urandom);
      in_valid = (sent < 200);
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, add_lsb));
        sent++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", 32'(got), 32'd200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
